// File: rtl/wb_burst_mem.sv
// wb_burst_mem: Wishbone B4 registered-feedback burst memory.
//
// A DEPTH x dw word memory behind a Wishbone slave port that supports classic
// single transfers and registered-feedback bursts (constant address,
// linear incrementing, and 4/8/16-beat wrapping). The first beat of every
// transfer costs one cycle; burst beats then stream one per cycle. Accesses
// whose word index is beyond DEPTH terminate with a one-cycle error instead
// of an acknowledge.
//
// Ports:
//   wb_clk_i  - clock, everything is on its rising edge
//   wb_rst_i  - synchronous active-low reset (memory contents survive it)
//   wb_adr_i  - byte address, word index is wb_adr_i[aw-1:2]
//   wb_dat_i  - write data
//   wb_sel_i  - byte-lane write enables
//   wb_we_i   - write enable
//   wb_cyc_i  - bus cycle in progress
//   wb_stb_i  - transfer strobe
//   wb_cti_i  - cycle type identifier (001 constant, 010 incrementing)
//   wb_bte_i  - burst type extension (00 linear, 01/10/11 wrap 4/8/16)
//   wb_dat_o  - registered read data, valid while wb_ack_o is high
//   wb_ack_o  - transfer acknowledge
//   wb_err_o  - transfer error (out-of-range word index)
//   wb_rty_o  - retry, never used
module wb_burst_mem #(
  parameter int aw    = 32,
  parameter int dw    = 32,
  parameter int DEPTH = 1024
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic [aw-1:0] wb_adr_i,
  input  logic [dw-1:0] wb_dat_i,
  input  logic [3:0]    wb_sel_i,
  input  logic          wb_we_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic [2:0]    wb_cti_i,
  input  logic [1:0]    wb_bte_i,
  output logic [dw-1:0] wb_dat_o,
  output logic          wb_ack_o,
  output logic          wb_err_o,
  output logic          wb_rty_o
);

  localparam int IW = aw - 2;
  localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = dw / 4;

  typedef enum logic {IDLE, BURST} state_t;

  state_t        state;
  state_t        state_d;

  logic [dw-1:0] mem [DEPTH];

  logic          req;
  logic          is_burst;
  logic          start;
  logic          burst_continue;
  logic [IW-1:0] cur_idx;
  logic [IW-1:0] nxt_idx;
  logic          cur_in_range;
  logic          nxt_in_range;
  logic          ack_d;
  logic          err_d;
  logic          rd_en;
  logic          wr_en;
  logic [IW-1:0] rd_idx;
  logic [dw-1:0] wr_word;
  logic [dw-1:0] rd_word;
  logic          unused_adr_bits;

  // The full word index is compared so that aliases above DEPTH are caught.
  function automatic logic in_range(input logic [IW-1:0] idx);
    return {1'b0, idx} < (IW + 1)'(DEPTH);
  endfunction

  assign req             = wb_cyc_i & wb_stb_i;
  assign is_burst        = (wb_cti_i == 3'b001) || (wb_cti_i == 3'b010);
  assign cur_idx         = wb_adr_i[aw-1:2];
  assign cur_in_range    = in_range(cur_idx);
  assign nxt_in_range    = in_range(nxt_idx);
  assign wb_rty_o        = 1'b0;
  assign unused_adr_bits = ^wb_adr_i[1:0];

  // A fresh transfer may only start once the previous ack/err has cleared,
  // which is what spaces classic transfers one idle cycle apart.
  assign start          = (state == IDLE) && !wb_ack_o && !wb_err_o && req;
  assign burst_continue = wb_cyc_i && wb_ack_o && req && is_burst && nxt_in_range;

  // Address of the beat after the current one. Wrapping bursts only move the
  // low 2/3/4 bits; the rest of the index stays fixed.
  always_comb begin
    nxt_idx = cur_idx;
    if (wb_cti_i == 3'b010) begin
      case (wb_bte_i)
        2'b00:   nxt_idx      = cur_idx + IW'(1);
        2'b01:   nxt_idx[1:0] = cur_idx[1:0] + 2'd1;
        2'b10:   nxt_idx[2:0] = cur_idx[2:0] + 3'd1;
        default: nxt_idx[3:0] = cur_idx[3:0] + 4'd1;
      endcase
    end
  end

  // Byte-lane merge of the write data into the currently addressed word.
  always_comb begin
    wr_word = mem[cur_idx[MW-1:0]];
    for (int i = 0; i < 4; i++) begin
      if (wb_sel_i[i]) begin
        wr_word[i*LW +: LW] = wb_dat_i[i*LW +: LW];
      end
    end
  end

  // Forward the merged word when a constant-address burst reads back the
  // word being written on the same edge.
  always_comb begin
    rd_word = mem[rd_idx[MW-1:0]];
    if (wr_en && (rd_idx == cur_idx)) begin
      rd_word = wr_word;
    end
  end

  // State register.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic: stay in BURST only while beats keep streaming in range.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (burst_continue)  state_d = BURST;
      BURST:   if (!burst_continue) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: what ack/err/read data should look like after this edge,
  // and whether the beat completing on this edge writes memory.
  always_comb begin
    ack_d  = 1'b0;
    err_d  = 1'b0;
    rd_en  = 1'b0;
    wr_en  = 1'b0;
    rd_idx = cur_idx;
    if (wb_cyc_i && !wb_err_o) begin
      if (wb_ack_o) begin
        if (req) begin
          wr_en = wb_we_i && cur_in_range;
          if (is_burst) begin
            rd_idx = nxt_idx;
            if (nxt_in_range) begin
              ack_d = 1'b1;
              rd_en = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
        end
      end else if (start) begin
        if (cur_in_range) begin
          ack_d = 1'b1;
          rd_en = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

  // Registered bus outputs. Read data only moves on acknowledged beats so an
  // error leaves it untouched.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= ack_d;
      wb_err_o <= err_d;
      if (rd_en) begin
        wb_dat_o <= rd_word;
      end
    end
  end

  // Memory array, deliberately outside the reset so contents persist; a reset
  // edge still suppresses any write that was about to land.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i && wr_en) begin
      mem[cur_idx[MW-1:0]] <= wr_word;
    end
  end

endmodule

// File: tb/tb_wb_burst_mem.sv
// tb_wb_burst_mem: self-checking bench for wb_burst_mem.
//
// A Wishbone master task drives directed transfers; a transfer-level model of
// the memory and its bus responses predicts ack/err/data every cycle, and the
// directed tests also pin hand-computed literal results.
module tb_wb_burst_mem;

  localparam int DEPTH = 2048;

  logic        clk;
  logic        rst_n;
  logic [31:0] adr;
  logic [31:0] dat_i;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [31:0] dat_o;
  logic        ack;
  logic        err;
  logic        rty;

  int n_checks = 0;
  int n_fail   = 0;
  logic chk_en = 1'b0;

  // Beat descriptors for the master task and what it observed.
  logic [31:0] b_adr [16];
  logic [31:0] b_dat [16];
  logic [3:0]  b_sel [16];
  logic        b_we  [16];
  logic [2:0]  b_cti [16];
  logic [1:0]  b_bte [16];
  logic [31:0] r_dat [16];
  logic        r_ack [16];
  logic        r_err [16];
  int          r_wait[16];
  logic        post_ack;
  logic        post_err;
  logic [31:0] post_dat;

  // Reference model state.
  logic [31:0] m_mem   [DEPTH];
  logic        m_valid [DEPTH];
  logic        m_ack   = 1'b0;
  logic        m_err   = 1'b0;
  logic [31:0] m_dat   = '0;
  logic        m_known = 1'b0;

  wb_burst_mem #(.aw(32), .dw(32), .DEPTH(DEPTH)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst_n),
    .wb_adr_i (adr),
    .wb_dat_i (dat_i),
    .wb_sel_i (sel),
    .wb_we_i  (we),
    .wb_cyc_i (cyc),
    .wb_stb_i (stb),
    .wb_cti_i (cti),
    .wb_bte_i (bte),
    .wb_dat_o (dat_o),
    .wb_ack_o (ack),
    .wb_err_o (err),
    .wb_rty_o (rty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Word that follows word w in a burst, using modular arithmetic on the wrap span.
  function automatic int unsigned next_word(input int unsigned w, input logic [2:0] c, input logic [1:0] b);
    int unsigned span;
    if (c == 3'b001) return w;
    case (b)
      2'b00:   return (w + 1) & 32'h3FFF_FFFF;
      2'b01:   span = 4;
      2'b10:   span = 8;
      default: span = 16;
    endcase
    return (w - (w % span)) + ((w + 1) % span);
  endfunction

  // Transfer-level model: each edge decides the next response from the
  // request seen, whether a beat completes, and where the burst goes next.
  always @(posedge clk) begin : model
    int unsigned w;
    int unsigned nw;
    logic [31:0] merged;
    logic [10:0] wi;
    logic [10:0] nwi;
    if (!rst_n) begin
      m_ack <= 1'b0; m_err <= 1'b0; m_dat <= '0; m_known <= 1'b1;
    end else if (!cyc) begin
      m_ack <= 1'b0; m_err <= 1'b0;
    end else if (m_err) begin
      m_err <= 1'b0;
    end else begin
      w  = adr >> 2;
      wi = w[10:0];
      if (m_ack) begin
        m_ack <= 1'b0;
        if (stb) begin
          if (we && w < DEPTH) begin
            merged = m_mem[wi];
            for (int b = 0; b < 4; b++) if (sel[b]) merged[8*b +: 8] = dat_i[8*b +: 8];
            m_mem[wi]   = merged;
            m_valid[wi] = 1'b1;
          end
          if (cti == 3'b001 || cti == 3'b010) begin
            nw  = next_word(w, cti, bte);
            nwi = nw[10:0];
            if (nw < DEPTH) begin
              m_ack <= 1'b1; m_dat <= m_mem[nwi]; m_known <= m_valid[nwi];
            end else begin
              m_err <= 1'b1;
            end
          end
        end
      end else if (stb) begin
        if (w < DEPTH) begin
          m_ack <= 1'b1; m_dat <= m_mem[wi]; m_known <= m_valid[wi];
        end else begin
          m_err <= 1'b1;
        end
      end
    end
  end

  // Every cycle: DUT responses must match the model.
  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("ack", 32'(ack), 32'(m_ack));
      checkOutput("err", 32'(err), 32'(m_err));
      checkOutput("rty", 32'(rty), 32'd0);
      if (m_ack && m_known) checkOutput("dat", dat_o, m_dat);
    end
  end

  task automatic setBeat(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [2:0] c, input logic [1:0] b);
    b_we[i] = w; b_adr[i] = a; b_dat[i] = d; b_sel[i] = s; b_cti[i] = c; b_bte[i] = b;
  endtask

  // Run n beats as one bus cycle; optionally pull reset while beat abort_beat completes.
  task automatic applyStimulus(input int n, input int abort_beat);
    int waited;
    @(posedge clk); #1;
    cyc = 1'b1;
    for (int i = 0; i < n; i++) begin
      stb = 1'b1; adr = b_adr[i]; we = b_we[i]; dat_i = b_dat[i];
      sel = b_sel[i]; cti = b_cti[i]; bte = b_bte[i];
      waited = 0;
      @(negedge clk);
      while (!(ack || err) && waited < 8) begin
        waited++;
        @(negedge clk);
      end
      r_wait[i] = waited; r_dat[i] = dat_o; r_ack[i] = ack; r_err[i] = err;
      if (!(ack || err)) begin
        checkOutput("beat_response", 32'(ack | err), 32'd1);
        break;
      end
      if (i + 1 == abort_beat) begin
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        break;
      end
      @(posedge clk); #1;
      if (r_err[i]) break;
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0; cti = 3'b000; bte = 2'b00;
    @(negedge clk);
    post_ack = ack; post_err = err; post_dat = dat_o;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat_i = '0;
    sel = 4'h0; cti = 3'b000; bte = 2'b00;
    for (int i = 0; i < DEPTH; i++) begin m_mem[i] = '0; m_valid[i] = 1'b0; end

    // Reset state.
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    checkOutput("reset_ack", 32'(ack), 32'd0);
    checkOutput("reset_err", 32'(err), 32'd0);
    checkOutput("reset_dat", dat_o, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Classic write then classic read, strobe held across both.
    $display("[TB] classic write/read");
    setBeat(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b000, 2'b00);
    setBeat(1, 1'b0, 32'h10, 32'h0, 4'hF, 3'b000, 2'b00);
    applyStimulus(2, 0);
    checkOutput("classic_wr_latency", 32'(r_wait[0]), 32'd1);
    checkOutput("classic_rd_latency", 32'(r_wait[1]), 32'd1);
    checkOutput("classic_rd_data", r_dat[1], 32'hDEADBEEF);

    // Linear incrementing burst, 5 words from 0x0FFC, write then read.
    $display("[TB] linear burst");
    for (int i = 0; i < 5; i++)
      setBeat(i, 1'b1, 32'h0FFC + 4 * i, 32'h1000_0000 + i, 4'hF, (i == 4) ? 3'b111 : 3'b010, 2'b00);
    applyStimulus(5, 0);
    for (int i = 0; i < 5; i++) b_we[i] = 1'b0;
    applyStimulus(5, 0);
    for (int i = 1; i < 5; i++) checkOutput("linear_ack_continuous", 32'(r_wait[i]), 32'd0);
    for (int i = 0; i < 5; i++) checkOutput("linear_rd_data", r_dat[i], 32'h1000_0000 + i);
    checkOutput("linear_ack_drop", 32'(post_ack), 32'd0);

    // Wrap-4 read from 0x8 over A,B,C,D at 0x0..0xC.
    $display("[TB] wrap-4 burst");
    for (int i = 0; i < 4; i++)
      setBeat(i, 1'b1, 32'(4 * i), 32'hAAAA_0000 + 32'h1111_0000 * i, 4'hF, (i == 3) ? 3'b111 : 3'b010, 2'b00);
    applyStimulus(4, 0);
    setBeat(0, 1'b0, 32'h8, 32'h0, 4'hF, 3'b010, 2'b01);
    setBeat(1, 1'b0, 32'hC, 32'h0, 4'hF, 3'b010, 2'b01);
    setBeat(2, 1'b0, 32'h0, 32'h0, 4'hF, 3'b010, 2'b01);
    setBeat(3, 1'b0, 32'h4, 32'h0, 4'hF, 3'b111, 2'b01);
    applyStimulus(4, 0);
    checkOutput("wrap_beat0", r_dat[0], 32'hCCCC0000);
    checkOutput("wrap_beat1", r_dat[1], 32'hDDDD0000);
    checkOutput("wrap_beat2", r_dat[2], 32'hAAAA0000);
    checkOutput("wrap_beat3", r_dat[3], 32'hBBBB0000);

    // Partial byte-lane write.
    $display("[TB] byte lanes");
    setBeat(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'hF, 3'b000, 2'b00);
    setBeat(1, 1'b1, 32'h20, 32'h11223344, 4'h5, 3'b000, 2'b00);
    setBeat(2, 1'b0, 32'h20, 32'h0, 4'hF, 3'b000, 2'b00);
    applyStimulus(3, 0);
    checkOutput("sel_merge", r_dat[2], 32'hFF22FF44);

    // Write to word index DEPTH: error, no ack, nothing written (word 0 holds A).
    $display("[TB] out of range");
    setBeat(0, 1'b1, 32'(DEPTH * 4), 32'hBAD0BAD0, 4'hF, 3'b000, 2'b00);
    applyStimulus(1, 0);
    checkOutput("oor_err", 32'(r_err[0]), 32'd1);
    checkOutput("oor_no_ack", 32'(r_ack[0]), 32'd0);
    checkOutput("oor_err_one_cycle", 32'(post_err), 32'd0);
    setBeat(0, 1'b0, 32'h0, 32'h0, 4'hF, 3'b000, 2'b00);
    applyStimulus(1, 0);
    checkOutput("oor_mem_unchanged", r_dat[0], 32'hAAAA0000);

    // Burst running off the end of memory.
    setBeat(0, 1'b0, 32'(DEPTH * 4 - 4), 32'h0, 4'hF, 3'b010, 2'b00);
    setBeat(1, 1'b0, 32'(DEPTH * 4), 32'h0, 4'hF, 3'b111, 2'b00);
    applyStimulus(2, 0);
    checkOutput("burst_edge_ack", 32'(r_ack[0]), 32'd1);
    checkOutput("burst_edge_err", 32'(r_err[1]), 32'd1);

    // Reset on the third beat of an 8-beat write burst.
    $display("[TB] reset mid-burst");
    for (int i = 0; i < 8; i++)
      setBeat(i, 1'b1, 32'h800 + 4 * i, 32'hA5A5_0000 + i, 4'hF, (i == 7) ? 3'b111 : 3'b010, 2'b00);
    applyStimulus(8, 0);
    for (int i = 0; i < 8; i++) b_dat[i] = 32'h5A5A_0000 + i;
    applyStimulus(8, 3);
    checkOutput("abort_ack", 32'(post_ack), 32'd0);
    checkOutput("abort_dat", post_dat, 32'd0);
    for (int i = 0; i < 3; i++)
      setBeat(i, 1'b0, 32'h800 + 4 * i, 32'h0, 4'hF, (i == 2) ? 3'b111 : 3'b010, 2'b00);
    applyStimulus(3, 0);
    checkOutput("abort_beat1_stored", r_dat[0], 32'h5A5A0000);
    checkOutput("abort_beat2_stored", r_dat[1], 32'h5A5A0001);
    checkOutput("abort_beat3_dropped", r_dat[2], 32'hA5A50002);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
